// File: rtl/i2c_slave.sv
// i2c_slave: I2C target with fixed 7-bit address, byte sink on master write and byte source on master read
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] wr_data,
  output logic       wr_valid,
  input  logic [7:0] rd_data,
  output logic       rd_req,
  output logic       busy
);
  localparam logic [2:0] IDLE = 3'd0, ADDR = 3'd1, ACK_ADDR = 3'd2, WRITE = 3'd3,
                         ACK_WRITE = 3'd4, READ = 3'd5, READ_ACK = 3'd6, WAIT_STOP = 3'd7;
  logic [SYNC_STAGES-1:0] scl_q, sda_q;
  logic       scl_s, sda_s, scl_p, sda_p, scl_rise, scl_fall, start, stop, load, match, rw;
  logic [2:0] state;
  logic [3:0] cnt;
  logic [7:0] sr;
  assign scl_s    = scl_q[SYNC_STAGES-1];
  assign sda_s    = sda_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_p;
  assign scl_fall = ~scl_s & scl_p;
  assign start    = scl_s & sda_p & ~sda_s;
  assign stop     = scl_s & ~sda_p & sda_s;
  assign match    = sr[7:1] == SLAVE_ADDR;
  assign load     = scl_fall & ((state == ACK_ADDR & rw) | (state == READ_ACK & cnt[0]));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      scl_q <= '1;
      sda_q <= '1;
      scl_p <= 1'b1;
      sda_p <= 1'b1;
    end else begin
      scl_q <= {scl_q[SYNC_STAGES-2:0], scl};
      sda_q <= {sda_q[SYNC_STAGES-2:0], sda_i};
      scl_p <= scl_s;
      sda_p <= sda_s;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      sr       <= '0;
      rw       <= 1'b0;
      sda_oe   <= 1'b0;
      wr_data  <= '0;
      wr_valid <= 1'b0;
      rd_req   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      wr_valid <= 1'b0;
      rd_req   <= load;
      if (stop) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
        cnt    <= '0;
      end else if (start) begin
        state  <= ADDR;
        sda_oe <= 1'b0;
        cnt    <= '0;
      end else if (load) begin
        sr     <= rd_data;
        sda_oe <= ~rd_data[7];
        cnt    <= 4'd1;
        state  <= READ;
      end else
        case (state)
          ADDR:
            if (scl_rise && !cnt[3]) begin
              sr  <= {sr[6:0], sda_s};
              cnt <= cnt + 4'd1;
            end else if (scl_fall && cnt[3]) begin
              rw     <= sr[0];
              busy   <= match;
              sda_oe <= match;
              state  <= match ? ACK_ADDR : WAIT_STOP;
            end
          ACK_ADDR, ACK_WRITE:
            if (scl_fall) begin
              sda_oe <= 1'b0;
              cnt    <= '0;
              state  <= WRITE;
            end
          WRITE:
            if (scl_rise && !cnt[3]) begin
              sr  <= {sr[6:0], sda_s};
              cnt <= cnt + 4'd1;
              if (cnt == 4'd7) begin
                wr_data  <= {sr[6:0], sda_s};
                wr_valid <= 1'b1;
              end
            end else if (scl_fall && cnt[3]) begin
              sda_oe <= 1'b1;
              state  <= ACK_WRITE;
            end
          READ:
            if (scl_fall) begin
              sr     <= {sr[6:0], 1'b0};
              sda_oe <= cnt[3] ? 1'b0 : ~sr[6];
              cnt    <= cnt[3] ? 4'd0 : cnt + 4'd1;
              state  <= cnt[3] ? READ_ACK : READ;
            end
          READ_ACK:
            if (scl_rise) begin
              if (sda_s) state <= WAIT_STOP;
              else cnt <= 4'd1;
            end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bus-level master model with scoreboards for written and read bytes
module tb_i2c_slave;
  localparam int Q = 40;
  logic       clk = 1'b0, reset = 1'b1, scl_m = 1'b1, sda_m = 1'b1;
  logic       sda_i, sda_oe, wr_valid, rd_req, busy, wr_prev = 1'b0, rd_prev = 1'b0;
  logic [7:0] wr_data, rd_data = 8'h00;
  int         checks = 0, errors = 0, wr_cnt = 0, rd_cnt = 0, oe_cnt = 0, busy_cnt = 0, viol = 0;
  logic [7:0] wr_exp[$], wr_got[$], rd_exp[$];
  assign sda_i = sda_m & ~sda_oe;
  i2c_slave dut (
    .clk(clk), .reset(reset), .scl(scl_m), .sda_i(sda_i), .sda_oe(sda_oe),
    .wr_data(wr_data), .wr_valid(wr_valid), .rd_data(rd_data), .rd_req(rd_req), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (wr_valid) begin
      wr_cnt <= wr_cnt + 1;
      wr_got.push_back(wr_data);
    end
    if (rd_req) rd_cnt <= rd_cnt + 1;
    if ((wr_valid && (rd_req || wr_prev)) || (rd_req && rd_prev)) viol <= viol + 1;
    wr_prev <= wr_valid;
    rd_prev <= rd_req;
  end
  task automatic bit_io(input logic b, output logic r);
    sda_m = b;
    #Q scl_m = 1'b1;
    #Q r = sda_i;
    #Q scl_m = 1'b0;
    #Q;
  endtask
  task automatic start_cond();
    sda_m = 1'b1;
    #Q scl_m = 1'b1;
    #Q sda_m = 1'b0;
    #Q scl_m = 1'b0;
    #Q;
  endtask
  task automatic stop_cond();
    sda_m = 1'b0;
    #Q scl_m = 1'b1;
    #Q sda_m = 1'b1;
    #Q;
  endtask
  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_io(d[i], r);
    bit_io(1'b1, r);
    ack = ~r;
  endtask
  task automatic read_byte(input logic ack, input logic [7:0] next, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, r);
      d[i] = r;
    end
    if (ack) begin
      rd_data = next;
      rd_exp.push_back(next);
    end
    bit_io(~ack, r);
  endtask
  task automatic test_reset();
    #1;
    checks++;
    if ({sda_oe, wr_valid, rd_req, busy} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b expected 0000", {sda_oe, wr_valid, rd_req, busy});
    end
    checks++;
    if (wr_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_wr_data got %02h expected 00", wr_data);
    end
    checks++;
    if (dut.state !== 3'd0 || dut.cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_state got %0d/%0d expected 0/0", dut.state, dut.cnt);
    end
    #29 reset = 1'b0;
  endtask
  task automatic test_write();
    logic a0, a1, a2;
    logic [7:0] e, g;
    int w0 = wr_cnt;
    wr_exp.push_back(8'hA5);
    wr_exp.push_back(8'h3C);
    start_cond();
    send_byte(8'h84, a0);
    send_byte(8'hA5, a1);
    send_byte(8'h3C, a2);
    checks++;
    if ({a0, a1, a2} !== 3'b111) begin
      errors++;
      $display("FAIL write_acks got %b expected 111", {a0, a1, a2});
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL write_busy_mid got %b expected 1", busy);
    end
    stop_cond();
    #Q;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL write_busy_stop got %b expected 0", busy);
    end
    checks++;
    if (wr_cnt - w0 !== 2) begin
      errors++;
      $display("FAIL write_count got %0d expected 2", wr_cnt - w0);
    end
    while (wr_exp.size() > 0) begin
      e = wr_exp.pop_front();
      g = wr_got.size() > 0 ? wr_got.pop_front() : 8'hxx;
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL write_data got %02h expected %02h", g, e);
      end
    end
  endtask
  task automatic test_nack();
    logic a0, a1;
    int o0 = oe_cnt, b0 = busy_cnt, w0 = wr_cnt;
    start_cond();
    send_byte(8'h2E, a0);
    send_byte(8'hFF, a1);
    stop_cond();
    #Q;
    checks++;
    if ({a0, a1} !== 2'b00) begin
      errors++;
      $display("FAIL nack_acks got %b expected 00", {a0, a1});
    end
    checks++;
    if (oe_cnt - o0 !== 0 || busy_cnt - b0 !== 0) begin
      errors++;
      $display("FAIL nack_drive got oe=%0d busy=%0d cycles expected 0/0", oe_cnt - o0, busy_cnt - b0);
    end
    checks++;
    if (wr_cnt - w0 !== 0) begin
      errors++;
      $display("FAIL nack_wr_valid got %0d expected 0", wr_cnt - w0);
    end
  endtask
  task automatic test_read();
    logic a0;
    logic [7:0] d0, d1, e;
    int r0 = rd_cnt;
    rd_data = 8'h96;
    rd_exp.push_back(8'h96);
    start_cond();
    send_byte(8'h85, a0);
    read_byte(1'b1, 8'h01, d0);
    e = rd_exp.pop_front();
    checks++;
    if (d0 !== e) begin
      errors++;
      $display("FAIL read_byte0 got %02h expected %02h", d0, e);
    end
    read_byte(1'b0, 8'h00, d1);
    e = rd_exp.pop_front();
    checks++;
    if (d1 !== e) begin
      errors++;
      $display("FAIL read_byte1 got %02h expected %02h", d1, e);
    end
    checks++;
    if (a0 !== 1'b1) begin
      errors++;
      $display("FAIL read_addr_ack got %b expected 1", a0);
    end
    checks++;
    if (sda_oe !== 1'b0 || dut.state !== 3'd7) begin
      errors++;
      $display("FAIL read_after_nack got oe=%b state=%0d expected 0/7", sda_oe, dut.state);
    end
    stop_cond();
    #Q;
    checks++;
    if (rd_cnt - r0 !== 2) begin
      errors++;
      $display("FAIL read_rd_req got %0d expected 2", rd_cnt - r0);
    end
  endtask
  task automatic test_repeated_start();
    logic a0, a1, a2;
    logic [7:0] d, e, g;
    int w0 = wr_cnt, r0 = rd_cnt;
    wr_exp.push_back(8'h10);
    rd_data = 8'h5A;
    rd_exp.push_back(8'h5A);
    start_cond();
    send_byte(8'h84, a0);
    send_byte(8'h10, a1);
    start_cond();
    send_byte(8'h85, a2);
    read_byte(1'b0, 8'h00, d);
    stop_cond();
    #Q;
    checks++;
    if ({a0, a1, a2} !== 3'b111) begin
      errors++;
      $display("FAIL rs_acks got %b expected 111", {a0, a1, a2});
    end
    e = wr_exp.pop_front();
    g = wr_got.size() > 0 ? wr_got.pop_front() : 8'hxx;
    checks++;
    if (g !== e || wr_cnt - w0 !== 1) begin
      errors++;
      $display("FAIL rs_write got %02h x%0d expected %02h x1", g, wr_cnt - w0, e);
    end
    e = rd_exp.pop_front();
    checks++;
    if (d !== e || rd_cnt - r0 !== 1) begin
      errors++;
      $display("FAIL rs_read got %02h x%0d expected %02h x1", d, rd_cnt - r0, e);
    end
  endtask
  task automatic test_stop_mid();
    logic a0, r;
    int w0 = wr_cnt;
    start_cond();
    send_byte(8'h84, a0);
    for (int i = 0; i < 4; i++) bit_io(i[0], r);
    stop_cond();
    #Q;
    checks++;
    if (a0 !== 1'b1 || wr_cnt - w0 !== 0) begin
      errors++;
      $display("FAIL stop_mid_write got ack=%b wr=%0d expected 1/0", a0, wr_cnt - w0);
    end
    checks++;
    if (dut.state !== 3'd0 || dut.cnt !== 4'd0 || sda_oe !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_mid_idle got state=%0d cnt=%0d oe=%b busy=%b expected 0/0/0/0",
               dut.state, dut.cnt, sda_oe, busy);
    end
  endtask
  task automatic test_reset_ack();
    logic a0, r;
    logic [7:0] addr = 8'h84;
    start_cond();
    for (int i = 7; i >= 0; i--) bit_io(addr[i], r);
    checks++;
    if (sda_oe !== 1'b1 || dut.state !== 3'd2) begin
      errors++;
      $display("FAIL rst_pre_ack got oe=%b state=%0d expected 1/2", sda_oe, dut.state);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({sda_oe, wr_valid, rd_req, busy} !== 4'b0 || wr_data !== 8'h00 || dut.state !== 3'd0) begin
      errors++;
      $display("FAIL rst_async got ctrl=%b wr_data=%02h state=%0d expected 0000/00/0",
               {sda_oe, wr_valid, rd_req, busy}, wr_data, dut.state);
    end
    #9 reset = 1'b0;
    start_cond();
    send_byte(8'h84, a0);
    checks++;
    if (a0 !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_recover got ack=%b busy=%b expected 1/1", a0, busy);
    end
    stop_cond();
    #Q;
  endtask
  task automatic test_pulses();
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL pulse_rules got %0d violations expected 0", viol);
    end
    checks++;
    if (wr_got.size() !== 0 || rd_exp.size() !== 0) begin
      errors++;
      $display("FAIL leftover got wr=%0d rd=%0d expected 0/0", wr_got.size(), rd_exp.size());
    end
  endtask
  initial begin
    test_reset();
    test_write();
    test_nack();
    test_read();
    test_repeated_start();
    test_stop_mid();
    test_reset_ack();
    test_pulses();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C target (responder) for the single-master bus driven by the team's I2C master.
- Oversamples SCL/SDA with the system clock, detects START/STOP, matches a fixed 7-bit address, ACKs, and then either receives bytes (master write) or serves bytes (master read).
- Sits between the bus pins and a register/FIFO user interface.

Parameters:
- SLAVE_ADDR, 7'h42, 7-bit address this target responds to.
- SYNC_STAGES, 2, synchronizer depth on scl and sda_i (minimum 2).

Ports:
- clk  in  1  system clock, at least 8x the SCL frequency.
- reset  in  1  asynchronous, active-high.
- scl  in  1  bus clock from the master.
- sda_i  in  1  bus data as seen on the wire.
- sda_oe  out  1  1 = pull SDA low; 0 = release (open-drain).
- wr_data  out  8  last byte received from the master.
- wr_valid  out  1  one-clk pulse: wr_data is a new byte.
- rd_data  in  8  byte to send on the next read byte.
- rd_req  out  1  one-clk pulse: rd_data was just loaded; present the next byte.
- busy  out  1  high from an address-matched START until STOP.

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk. All logic is on posedge clk.
- Reset values: sda_oe=0, wr_data=0, wr_valid=0, rd_req=0, busy=0, state=IDLE, bit counter=0.
- scl and sda_i each pass through SYNC_STAGES flops. A previous-sample register gives scl_rise, scl_fall, sda_rise and sda_fall.
- START = sda_fall while synced scl=1. STOP = sda_rise while synced scl=1. Both take priority over any bit sampling in the same clk.
- Data is sampled on scl_rise. sda_oe changes only on scl_fall, except that STOP and START release sda_oe immediately.
- States:
  - IDLE: on START go to ADDR, count=0.
  - ADDR: shift 8 bits MSB first (7 address bits, then R/W) on scl_rise. After the 8th bit:
    - Match: on the next scl_fall set sda_oe=1 and go to ACK_ADDR; busy=1.
    - Mismatch: go to WAIT_STOP and never drive SDA.
  - ACK_ADDR: hold sda_oe=1 through the 9th SCL pulse. On the following scl_fall:
    - R/W=0: release SDA and go to WRITE.
    - R/W=1: load the shift register from rd_data, pulse rd_req, drive bit7 (sda_oe = ~bit), and go to READ.
  - WRITE: shift 8 bits on scl_rise. After the 8th bit, wr_data <= byte and pulse wr_valid in the same clk. On the next scl_fall set sda_oe=1 and go to ACK_WRITE.
  - ACK_WRITE: on the scl_fall ending the 9th pulse, release SDA and return to WRITE with count=0.
  - READ: on each scl_fall after a bit, drive the next bit. After the 8th bit's scl_fall, release SDA and go to READ_ACK.
  - READ_ACK: sample the master's ACK on scl_rise.
    - 0 (ACK): on the next scl_fall reload from rd_data, pulse rd_req, drive bit7, and go to READ.
    - 1 (NACK): go to WAIT_STOP with SDA released.
  - WAIT_STOP: ignore bus activity until STOP or START.
- From any state, STOP leads to IDLE: sda_oe=0, busy=0, count cleared, any partial byte discarded (no wr_valid).
- From any state, START (repeated start) leads to ADDR: sda_oe=0, count=0. busy keeps its value until the new address is decoded.
- wr_valid and rd_req never assert in the same clk and never last longer than one clk.
- Asynchronous reset mid-transfer returns to IDLE immediately with SDA released. The next transaction needs a fresh START.
- Glitches shorter than SYNC_STAGES clks on scl are not filtered beyond the synchronizer; this is a documented limitation.

Test Plan:
- Write 0x42+W, data 0xA5, 0x3C, STOP -> ACK on all 3 bytes; wr_valid pulses twice with wr_data 0xA5 then 0x3C; busy falls at STOP.
- Address 0x17+W, data 0xFF -> sda_oe stays 0 for the whole transfer (NACK); no wr_valid; busy stays 0.
- Read 0x42+R with rd_data=0x96, master ACK, rd_data=0x01, master NACK, STOP -> SDA carries 10010110 then 00000001; rd_req pulses twice; SDA is released after the NACK.
- Write 0x42+W, 0x10, repeated START, 0x42+R, master NACK -> wr_valid once with 0x10, then the read byte equals rd_data; no STOP is needed between the two phases.
- STOP after 4 bits of a write byte -> no wr_valid, state=IDLE, sda_oe=0, busy=0.
- reset asserted during the ACK_ADDR low phase -> sda_oe=0 in the same cycle and all outputs at their reset values; the next START plus 0x42 is ACKed normally.
